// File: rtl/disp_pkg.sv
// Shared definitions for the LED-matrix frame upload path.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package disp_pkg;

  // Frame geometry: 8x8 cells, row-major (row*8+col), 2 bits per cell.
  localparam int CELL_W  = 2;
  localparam int ADDR_W  = 6;
  localparam int N_CELLS = 1 << ADDR_W;

  // Width of the inter-upload gap counter; covers gaps of 1..255 cycles.
  localparam int GAP_W = 8;

  // Colour codes as understood by the matrix driver.
  typedef enum logic [CELL_W-1:0] {
    C_OFF = 2'd0,
    C_RED = 2'd1,
    C_GRN = 2'd2,
    C_ORG = 2'd3
  } cell_e;

  // Upload sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } state_e;

  // Two-way round-robin pick: a lone request wins outright; on a tie the
  // requester that was not served last wins. Result is one-hot or zero.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_served);
    logic [1:0] pick;
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_served ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/disp_upload_sched_rr_arb2.sv
// Two-requester round-robin arbiter with a last-served history bit.
// Latency: grant is combinational from req; history updates on the clock after upd_i.
// Backpressure: none; the caller decides when a grant is taken and when to update.
module rr_arb2
  import disp_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_id_i,
  output logic [1:0] gnt_o,
  output logic       last_served_o
);

  logic last_served_q;
  logic last_served_d;

  // Record who finished last so the other side wins the next tie.
  always_comb begin
    last_served_d = last_served_q;
    if (upd_i) begin
      last_served_d = upd_id_i;
    end
  end

  // History register; resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      last_served_q <= 1'b1;
    end else begin
      last_served_q <= last_served_d;
    end
  end

  // Combinational one-hot pick for the sequencer to register.
  always_comb begin
    gnt_o = rr_pick(req_i, last_served_q);
  end

  assign last_served_o = last_served_q;

endmodule

// File: rtl/disp_upload_sched.sv
// Arbitrates two frame sources and streams a whole 64-cell frame into the LED driver.
// Latency: gnt/rd_addr=0 one cycle after req seen in IDLE, first beat 2 cycles later, done 66 cycles after grant.
// Backpressure: none on the driver side; requests wait (level) while an upload or its gap is in progress.
module disp_upload_sched
  import disp_pkg::*;
#(
  // Idle cycles between consecutive uploads, 1..255.
  parameter int GAP_CYCLES = 4
)
(
  input  logic              clk,
  input  logic              nrst,
  input  logic [1:0]        req,
  output logic [1:0]        gnt,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [CELL_W-1:0] rd_data0,
  input  logic [CELL_W-1:0] rd_data1,
  output logic              disp_enable,
  output logic [CELL_W-1:0] disp_data,
  output logic [1:0]        done,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_CELLS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  // Sequencer state and registered control outputs.
  state_e              state_q;
  logic [1:0]          gnt_q;
  logic                owner_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [1:0]          done_q;
  logic                drain_q;
  logic [GAP_W-1:0]    gap_cnt_q;

  // Read / output pipeline.
  logic                rd_vld_q;
  logic                rd_vld_d;
  logic                disp_enable_q;
  logic                disp_enable_d;
  logic [CELL_W-1:0]   disp_data_q;
  logic [CELL_W-1:0]   disp_data_d;

  // Arbiter interface.
  logic [1:0]          arb_gnt;
  logic                arb_upd;
  logic                last_served;

  // History advances in the same cycle that done is raised.
  assign arb_upd = (state_q == DRAIN) && drain_q;

  rr_arb2 u_arb (
    .clk           (clk),
    .nrst          (nrst),
    .req_i         (req),
    .upd_i         (arb_upd),
    .upd_id_i      (owner_q),
    .gnt_o         (arb_gnt),
    .last_served_o (last_served)
  );

  // Upload sequencer: grant, address walk, pipeline drain, inter-frame gap.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q   <= IDLE;
      gnt_q     <= 2'b00;
      owner_q   <= 1'b0;
      busy_q    <= 1'b0;
      rd_addr_q <= '0;
      done_q    <= 2'b00;
      drain_q   <= 1'b0;
      gap_cnt_q <= '0;
    end else begin
      done_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (|arb_gnt) begin
            gnt_q     <= arb_gnt;
            owner_q   <= arb_gnt[1];
            busy_q    <= 1'b1;
            rd_addr_q <= '0;
            state_q   <= FETCH;
          end
        end
        FETCH: begin
          // Address 63 is presented for one cycle, then held as don't-care.
          if (rd_addr_q == LAST_ADDR) begin
            drain_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // Two cycles lets the last read and the output register empty.
          if (drain_q) begin
            done_q[owner_q] <= 1'b1;
            gnt_q           <= 2'b00;
            gap_cnt_q       <= '0;
            state_q         <= GAP;
          end else begin
            drain_q <= 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Read data is valid the cycle after an address was presented in FETCH;
  // the owner select comes from a register so it is stable for the whole frame.
  always_comb begin
    rd_vld_d      = (state_q == FETCH);
    disp_enable_d = rd_vld_q;
    disp_data_d   = '0;
    if (rd_vld_q) begin
      disp_data_d = owner_q ? rd_data1 : rd_data0;
    end
  end

  // Pipeline registers feeding the driver load port.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      rd_vld_q      <= 1'b0;
      disp_enable_q <= 1'b0;
      disp_data_q   <= '0;
    end else begin
      rd_vld_q      <= rd_vld_d;
      disp_enable_q <= disp_enable_d;
      disp_data_q   <= disp_data_d;
    end
  end

  assign gnt         = gnt_q;
  assign rd_addr     = rd_addr_q;
  assign disp_enable = disp_enable_q;
  assign disp_data   = disp_data_q;
  assign done        = done_q;
  assign busy        = busy_q;

  // Grant never names both sources at once.
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (nrst) $onehot0(gnt_q));

  // A completion pulse only ever names the current owner.
  a_done_owner: assert property (@(posedge clk) disable iff (nrst)
                                 (|done_q) |-> (done_q[last_served] && $onehot(done_q)));

endmodule

// File: tb/tb_disp_upload_sched.sv
// Directed bench for the frame upload scheduler.
// Latency: checks exact cycle positions of grant, beats, done and gap.
// Backpressure: n/a.
module tb_disp_upload_sched;

  logic       clk;
  logic       nrst;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [5:0] rd_addr;
  logic [1:0] rd_data0;
  logic [1:0] rd_data1;
  logic       disp_enable;
  logic [1:0] disp_data;
  logic [1:0] done;
  logic       busy;

  int n_tests;
  int n_fail;
  int bad_oh;

  logic [1:0] mem0 [64];
  logic [1:0] mem1 [64];

  disp_upload_sched #(.GAP_CYCLES(4)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .req         (req),
    .gnt         (gnt),
    .rd_addr     (rd_addr),
    .rd_data0    (rd_data0),
    .rd_data1    (rd_data1),
    .disp_enable (disp_enable),
    .disp_data   (disp_data),
    .done        (done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read frame buffers of the two sources.
  always @(posedge clk) begin
    rd_data0 <= mem0[rd_addr];
    rd_data1 <= mem1[rd_addr];
  end

  // Grant must never have both bits set.
  always @(negedge clk) begin
    if (!$onehot0(gnt)) bad_oh = bad_oh + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester 0 buffer: k mod 4; requester 1 buffer: 3 - (k mod 4).
  function automatic logic [1:0] exp_cell(input int id, input int k);
    logic [1:0] v;
    v = 2'(k % 4);
    if (id != 0) v = 2'd3 - v;
    return v;
  endfunction

  // Entered at the negedge of the IDLE cycle in which req is sampled.
  // At beat ev_beat req is replaced by ev_req. Returns at the done cycle.
  task automatic upload(input int id, input int ev_beat, input logic [1:0] ev_req);
    logic [1:0] oh;
    oh = (id == 0) ? 2'b01 : 2'b10;
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(oh));
    chk("rd_addr_start", 32'(rd_addr), 0);
    chk("busy_on", 32'(busy), 1);
    @(negedge clk);
    chk("en_before", 32'(disp_enable), 0);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      chk("beat", 32'({disp_enable, disp_data}), 32'({1'b1, exp_cell(id, k)}));
      if (k == ev_beat) req = ev_req;
    end
    @(negedge clk);
    chk("en_after", 32'(disp_enable), 0);
    chk("done", 32'(done), 32'(oh));
    chk("gnt_drop", 32'(gnt), 0);
  endtask

  // Entered at the done cycle; returns at the first IDLE cycle after the gap.
  task automatic gap_chk();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("gap_busy", 32'(busy), 1);
      if (i == 1) chk("done_pulse", 32'(done), 0);
    end
    @(negedge clk);
    chk("gap_end_busy", 32'(busy), 0);
    chk("gap_end_gnt", 32'(gnt), 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bad_oh  = 0;
    for (int k = 0; k < 64; k++) begin
      mem0[k] = exp_cell(0, k);
      mem1[k] = exp_cell(1, k);
    end

    // Reset values, with both requesters already asking.
    nrst = 1'b1;
    req  = 2'b11;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_en", 32'(disp_enable), 0);
    chk("rst_data", 32'(disp_data), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    nrst = 1'b0;

    // Contention from reset: grants alternate 0,1,0,1.
    upload(0, -1, 2'b11);
    gap_chk();
    upload(1, -1, 2'b11);
    gap_chk();
    upload(0, -1, 2'b11);
    gap_chk();
    upload(1, -1, 2'b11);
    req = 2'b00;
    gap_chk();

    // Single request / latency: req seen in IDLE cycle t.
    req = 2'b01;
    upload(0, -1, 2'b01);
    req = 2'b00;
    gap_chk();

    // Back-to-back: requester 1 arrives mid-upload, granted GAP+1 after done.
    req = 2'b01;
    upload(0, 20, 2'b11);
    req = 2'b10;
    gap_chk();
    // Early drop: requester 1 releases at beat 10, frame still completes.
    upload(1, 10, 2'b00);
    gap_chk();

    // Reset at beat 30 aborts the stream asynchronously.
    req = 2'b01;
    @(negedge clk);
    chk("mid_gnt", 32'(gnt), 1);
    @(negedge clk);
    repeat (31) @(negedge clk);
    chk("mid_beat30", 32'({disp_enable, disp_data}), 32'({1'b1, exp_cell(0, 30)}));
    #1 nrst = 1'b1;
    #1;
    chk("arst_gnt", 32'(gnt), 0);
    chk("arst_rd_addr", 32'(rd_addr), 0);
    chk("arst_en", 32'(disp_enable), 0);
    chk("arst_data", 32'(disp_data), 0);
    chk("arst_busy", 32'(busy), 0);
    @(negedge clk);
    nrst = 1'b0;
    // Fresh full frame from cell 0 after the abort.
    upload(0, -1, 2'b01);
    req = 2'b00;
    gap_chk();

    chk("gnt_onehot0", 32'(bad_oh), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
